// File: rtl/constraint_merge_pkg.sv
// Shared solver types: merge FSM states, counter widths and a saturating helper.
package constraint_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SEEN_W = 32;
    localparam int PASS_W = 16;

    localparam logic [SEEN_W-1:0] SEEN_ONE = 32'd1;
    localparam logic [SEEN_W-1:0] SEEN_MAX = 32'hFFFF_FFFF;
    localparam logic [PASS_W-1:0] PASS_ONE = 16'd1;

    function automatic logic [SEEN_W-1:0] seen_inc(input logic [SEEN_W-1:0] v);
        if (v == SEEN_MAX) begin
            return v;
        end else begin
            return v + SEEN_ONE;
        end
    endfunction

endpackage

// File: rtl/constraint_merge_idx_fifo.sv
// First-word-fall-through FIFO of accepted candidate indices.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module idx_fifo #(
    parameter int IDX_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // A push while full is only legal when the head leaves in the same cycle.
    assign wr_en_s = push && (!full_s || pop);
    assign rd_en_s = pop && !empty_s;

    assign full  = full_s;
    assign empty = empty_s;
    assign head  = empty_s ? {IDX_W{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/constraint_merge.sv
// Merges per-split constraint results: forwards indices of candidates that
// satisfy every split until the requested number of passes has been collected.
module constraint_merge
    import constraint_merge_pkg::*;
#(
    parameter int NUM_SPLITS = 8,
    parameter int IDX_W      = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PASS_W-1:0]     target,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic [NUM_SPLITS-1:0] in_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic [SEEN_W-1:0]     seen_cnt,
    output logic [PASS_W-1:0]     pass_cnt,
    output logic                  busy,
    output logic                  done
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PASS_W-1:0]   target_r;
    logic [SEEN_W-1:0]   seen_cnt_r;
    logic [PASS_W-1:0]   pass_cnt_r;

    logic in_ready_s;
    logic busy_s;
    logic done_s;
    logic xfer_s;
    logic all_sat_s;
    logic push_s;
    logic pop_s;
    logic last_pass_s;
    logic start_take_s;
    logic fifo_full_s;
    logic fifo_empty_s;

    assign xfer_s       = in_valid && in_ready_s;
    assign all_sat_s    = &in_sat;
    assign push_s       = xfer_s && all_sat_s;
    assign pop_s        = !fifo_empty_s && out_ready;
    assign last_pass_s  = push_s && ((pass_cnt_r + PASS_ONE) == target_r);
    assign start_take_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    idx_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_idx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (in_idx),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (out_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero target completes without ever accepting input.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = (target == {PASS_W{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_pass_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register and the registered FIFO flags.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                in_ready_s = !fifo_full_s;
                busy_s     = 1'b1;
            end
            ST_DRAIN: busy_s = 1'b1;
            ST_DONE:  done_s = 1'b1;
            ST_IDLE:  busy_s = 1'b0;
            default:  busy_s = 1'b0;
        endcase
    end

    // Run counters and latched target; cleared only when a start is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r   <= {PASS_W{1'b0}};
            seen_cnt_r <= {SEEN_W{1'b0}};
            pass_cnt_r <= {PASS_W{1'b0}};
        end else if (start_take_s) begin
            target_r   <= target;
            seen_cnt_r <= {SEEN_W{1'b0}};
            pass_cnt_r <= {PASS_W{1'b0}};
        end else if (xfer_s) begin
            seen_cnt_r <= seen_inc(seen_cnt_r);
            if (all_sat_s) begin
                pass_cnt_r <= pass_cnt_r + PASS_ONE;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = !fifo_empty_s;
    assign seen_cnt  = seen_cnt_r;
    assign pass_cnt  = pass_cnt_r;
    assign busy      = busy_s;
    assign done      = done_s;

endmodule
